// File: rtl/adder4_job_sequencer_if.sv
// Job/operand/result bundle between the sequencer, its job source, the shared
// 4-lane adder and the downstream sum consumer.
interface adder4_job_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                    start;
  logic [LEN_WIDTH-1:0]    len;
  logic                    busy;
  logic                    done;
  logic                    in_valid;
  logic                    in_ready;
  logic [4*DATA_WIDTH-1:0] in_a;
  logic [4*DATA_WIDTH-1:0] in_b;
  logic [4*DATA_WIDTH-1:0] add_a;
  logic [4*DATA_WIDTH-1:0] add_b;
  logic [4*DATA_WIDTH-1:0] add_sum;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*DATA_WIDTH-1:0] out_sum;
  logic                    out_last;
  logic [LEN_WIDTH-1:0]    beats_left;

  modport slave (
    input  start, len, in_valid, in_a, in_b, add_sum, out_ready,
    output busy, done, in_ready, add_a, add_b, out_valid, out_sum, out_last, beats_left
  );

  modport master (
    output start, len, in_valid, in_a, in_b, add_sum, out_ready,
    input  busy, done, in_ready, add_a, add_b, out_valid, out_sum, out_last, beats_left
  );
endinterface

// File: rtl/adder4_job_sequencer.sv
// Streams vector-add job beats through an external combinational 4-lane adder
// into a single-entry output register, with a one-cycle done pulse per job.
module adder4_job_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  adder4_job_sequencer_if.slave bus
);
  // state | meaning
  // IDLE  | no job; start with len!=0 opens a job, len==0 just pulses done
  // RUN   | accepting operand beats, one per cycle while the output slot frees
  // DRAIN | all beats accepted; waiting for the final sum to be popped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic                    busy_q;
  logic                    done_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [4*DATA_WIDTH-1:0] out_sum_q;
  logic [LEN_WIDTH-1:0]    beats_left_q;
  logic                    accept;
  logic                    pop;

  assign bus.add_a      = bus.in_a;
  assign bus.add_b      = bus.in_b;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.beats_left = beats_left_q;

  // Ready looks only at state and the output slot, never at in_valid.
  assign bus.in_ready = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_sum_q    <= '0;
      beats_left_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              state        <= RUN;
              beats_left_q <= bus.len;
              busy_q       <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            out_sum_q    <= bus.add_sum;
            out_valid_q  <= 1'b1;
            beats_left_q <= beats_left_q - LEN_WIDTH'(1);
            out_last_q   <= (beats_left_q == LEN_WIDTH'(1));
            if (beats_left_q == LEN_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end else if (pop) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (pop && out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
